// File: rtl/frame_color_analyzer_pkg.sv
// Shared camera definitions: frame geometry, color codes and the analyzer FSM
// state encoding. The capture, display and analysis blocks all import this package,
// so they agree on frame size and on what each color code means.
package frame_color_analyzer_pkg;

    // Camera frame geometry in pixels
    localparam int CAM_SCREEN_X = 160;
    localparam int CAM_SCREEN_Y = 120;

    // Dominant-color result codes
    typedef enum logic [1:0] {
        NONE  = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10,
        BLUE  = 2'b11
    } color_t;

    // Analyzer sequencing states
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/frame_color_analyzer_if.sv
// Frame analyzer bus: start/busy/done handshake, frame-buffer read port and
// the result outputs.
//   master : the analyzer (drives address, status and results)
//   slave  : the host / frame-buffer side (drives start and read data)
// Signals:
//   start        request one full-frame analysis
//   mem_addr     frame-buffer read address (AW bits)
//   mem_data     frame-buffer read data, valid one cycle after mem_addr (DW bits)
//   busy         analysis in progress
//   done         one-cycle pulse when results have been updated
//   color        dominant color code (see color_t)
//   *_count      per-class pixel totals of the last completed frame (AW bits)
interface frame_color_analyzer_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          done;
    logic [1:0]    color;
    logic [AW-1:0] red_count;
    logic [AW-1:0] green_count;
    logic [AW-1:0] blue_count;

    modport master (
        input  start, mem_data,
        output mem_addr, busy, done, color, red_count, green_count, blue_count
    );

    modport slave (
        output start, mem_data,
        input  mem_addr, busy, done, color, red_count, green_count, blue_count
    );
endinterface

// File: rtl/pixel_classify.sv
// Combinational RGB332 pixel classifier.
// A pixel belongs to a class when that channel is in the upper half of its
// range (>= 4) and strictly brighter than both other channels; at most one of
// the outputs can therefore be high. The 2-bit blue channel is widened to
// 3 bits by repeating its MSB so all channels compare on the same 0..7 scale.
// Ports:
//   pixel    input  DW-bit RGB332 pixel
//   is_red   output pixel is predominantly red
//   is_green output pixel is predominantly green
//   is_blue  output pixel is predominantly blue
module pixel_classify #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] pixel,
    output logic          is_red,
    output logic          is_green,
    output logic          is_blue
);
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b3;

    assign r  = pixel[7:5];
    assign g  = pixel[4:2];
    assign b3 = {pixel[1:0], pixel[1]};

    // Bit 2 set is the same as channel >= 4
    assign is_red   = r[2]  && (r  > g) && (r  > b3);
    assign is_green = g[2]  && (g  > r) && (g  > b3);
    assign is_blue  = b3[2] && (b3 > r) && (b3 > g);
endmodule

// File: rtl/frame_color_analyzer.sv
// Full-frame dominant color analyzer.
// On start, reads every pixel of the frame buffer once (addresses 0..N-1),
// classifies each pixel as red, green, blue or none, and counts the classes.
// When the frame has been read, the totals and the dominant color are
// published and done pulses for one cycle.
// Ports:
//   clk   frame-buffer read clock
//   rst   synchronous active-high reset
//   bus   analyzer bus (master side): start/busy/done, mem_addr/mem_data,
//         color and red/green/blue_count results
module frame_color_analyzer #(
    parameter int CAM_SCREEN_X = frame_color_analyzer_pkg::CAM_SCREEN_X,
    parameter int CAM_SCREEN_Y = frame_color_analyzer_pkg::CAM_SCREEN_Y,
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int MIN_COUNT    = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    frame_color_analyzer_if.master bus
);
    import frame_color_analyzer_pkg::*;

    localparam int            N         = CAM_SCREEN_X * CAM_SCREEN_Y;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic          pix_vld;
    logic          is_red;
    logic          is_green;
    logic          is_blue;
    logic [AW-1:0] red_cnt;
    logic [AW-1:0] green_cnt;
    logic [AW-1:0] blue_cnt;
    logic [AW-1:0] red_res;
    logic [AW-1:0] green_res;
    logic [AW-1:0] blue_res;
    logic [1:0]    color_res;
    logic          done_q;

    // Largest class wins; strict '>' keeps the earlier class on a tie, giving
    // red > green > blue priority. Too few pixels means no decision.
    function automatic logic [1:0] pick_color(input logic [AW-1:0] r_cnt,
                                              input logic [AW-1:0] g_cnt,
                                              input logic [AW-1:0] b_cnt);
        logic [AW-1:0] best;
        logic [1:0]    code;
        best = r_cnt;
        code = RED;
        if (g_cnt > best) begin
            best = g_cnt;
            code = GREEN;
        end
        if (b_cnt > best) begin
            best = b_cnt;
            code = BLUE;
        end
        if (32'(best) < MIN_COUNT) begin
            code = NONE;
        end
        return code;
    endfunction

    pixel_classify #(
        .DW(DW)
    ) u_classify (
        .pixel    (bus.mem_data),
        .is_red   (is_red),
        .is_green (is_green),
        .is_blue  (is_blue)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    if (addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address walks 0..N-1 during READ and rests at 0 everywhere else, so the
    // first READ cycle always issues address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (state == READ && addr != LAST_ADDR) begin
            addr <= addr + 1'b1;
        end else begin
            addr <= '0;
        end
    end

    // Read data lags the address by one cycle: the pixel on mem_data is valid
    // in every READ cycle except the first, plus the single DRAIN cycle.
    assign pix_vld = (state == READ && addr != '0) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
        end else if (state == IDLE && bus.start) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
        end else if (pix_vld) begin
            if (is_red)   red_cnt   <= red_cnt + 1'b1;
            if (is_green) green_cnt <= green_cnt + 1'b1;
            if (is_blue)  blue_cnt  <= blue_cnt + 1'b1;
        end
    end

    // Results only change at the DONE->IDLE edge, together with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            red_res   <= '0;
            green_res <= '0;
            blue_res  <= '0;
            color_res <= NONE;
        end else begin
            done_q <= (state == DONE);
            if (state == DONE) begin
                red_res   <= red_cnt;
                green_res <= green_cnt;
                blue_res  <= blue_cnt;
                color_res <= pick_color(red_cnt, green_cnt, blue_cnt);
            end
        end
    end

    assign bus.mem_addr    = addr;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.color       = color_res;
    assign bus.red_count   = red_res;
    assign bus.green_count = green_res;
    assign bus.blue_count  = blue_res;
endmodule

// File: tb/tb_frame_color_analyzer.sv
// Bench for frame_color_analyzer: a full-size instance for the directed frame
// scenarios and a small instance for randomized frames, each fed by a
// behavioural frame-buffer model with one-cycle read latency.
module tb_frame_color_analyzer;
    import frame_color_analyzer_pkg::*;

    localparam int NB    = CAM_SCREEN_X * CAM_SCREEN_Y;
    localparam int SX    = 16;
    localparam int SY    = 8;
    localparam int NS    = SX * SY;
    localparam int MIN_S = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem  [0:NB-1];
    logic [7:0] smem [0:NS-1];

    always #5 clk = ~clk;

    frame_color_analyzer_if #(.AW(15), .DW(8)) bb ();
    frame_color_analyzer_if #(.AW(8),  .DW(8)) sb ();

    frame_color_analyzer #(
        .CAM_SCREEN_X (CAM_SCREEN_X),
        .CAM_SCREEN_Y (CAM_SCREEN_Y),
        .AW           (15),
        .DW           (8),
        .MIN_COUNT    (256)
    ) u_big (
        .clk (clk),
        .rst (rst),
        .bus (bb)
    );

    frame_color_analyzer #(
        .CAM_SCREEN_X (SX),
        .CAM_SCREEN_Y (SY),
        .AW           (8),
        .DW           (8),
        .MIN_COUNT    (MIN_S)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    // Frame buffers: synchronous read, data one cycle after the address
    always @(posedge clk) begin
        bb.mem_data <= (int'(bb.mem_addr) < NB) ? mem[bb.mem_addr] : 8'h00;
        sb.mem_data <= (int'(sb.mem_addr) < NS) ? smem[sb.mem_addr] : 8'h00;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference classification straight from the channel rules
    function automatic int model_class(input logic [7:0] d);
        int r, g, b;
        r = int'(d) / 32;
        g = (int'(d) / 4) % 8;
        b = (int'(d) % 4) * 2 + (int'(d) / 2) % 2;
        if (r >= 4 && r > g && r > b) return 1;
        if (g >= 4 && g > r && g > b) return 2;
        if (b >= 4 && b > r && b > g) return 3;
        return 0;
    endfunction

    function automatic int model_color(input int r, input int g, input int b, input int minc);
        int c[4];
        int best;
        c = '{0, r, g, b};
        best = 1;
        for (int k = 2; k < 4; k++) if (c[k] > c[best]) best = k;
        return (c[best] >= minc) ? best : 0;
    endfunction

    task automatic model_small(output int er, output int eg, output int eb, output int ec);
        int cnt[4];
        cnt = '{default: 0};
        for (int i = 0; i < NS; i++) cnt[model_class(smem[i])]++;
        er = cnt[1];
        eg = cnt[2];
        eb = cnt[3];
        ec = model_color(er, eg, eb, MIN_S);
    endtask

    // One full-size frame: pulse start, watch NB+8 cycles. Optionally re-pulse
    // start at cycle restart_at (must be ignored). Tracks busy, address and
    // result stability cycle by cycle.
    task automatic run_big(input int restart_at, output int done_at, output int n_done,
                           output int profile_bad);
        logic [14:0] pr, pg, pb;
        logic [1:0]  pc;
        done_at     = -1;
        n_done      = 0;
        profile_bad = 0;
        pr = bb.red_count;
        pg = bb.green_count;
        pb = bb.blue_count;
        pc = bb.color;
        @(negedge clk);
        bb.start = 1'b1;
        @(posedge clk);
        #1;
        bb.start = 1'b0;
        for (int k = 1; k <= NB + 8; k++) begin
            @(posedge clk);
            #1;
            bb.start = (k == restart_at);
            if (bb.done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (bb.busy !== (k <= NB + 1)) profile_bad++;
            if (int'(bb.mem_addr) != ((k < NB) ? k : 0)) profile_bad++;
            if (done_at < 0 && (bb.red_count !== pr || bb.green_count !== pg ||
                                bb.blue_count !== pb || bb.color !== pc)) profile_bad++;
        end
        bb.start = 1'b0;
    endtask

    task automatic run_small(input string tag);
        int er, eg, eb, ec, done_at;
        model_small(er, eg, eb, ec);
        done_at = -1;
        @(negedge clk);
        sb.start = 1'b1;
        @(posedge clk);
        #1;
        sb.start = 1'b0;
        for (int k = 1; k <= NS + 6; k++) begin
            @(posedge clk);
            #1;
            if (sb.done && done_at < 0) done_at = k;
        end
        check_eq({tag, "_done_at"}, 32'(done_at), 32'(NS + 2));
        check_eq({tag, "_red"},   32'(sb.red_count),   32'(er));
        check_eq({tag, "_green"}, 32'(sb.green_count), 32'(eg));
        check_eq({tag, "_blue"},  32'(sb.blue_count),  32'(eb));
        check_eq({tag, "_color"}, 32'(sb.color),       32'(ec));
    endtask

    task automatic check_big(input string tag, input int r, input int g, input int b, input int c);
        check_eq({tag, "_red"},   32'(bb.red_count),   32'(r));
        check_eq({tag, "_green"}, 32'(bb.green_count), 32'(g));
        check_eq({tag, "_blue"},  32'(bb.blue_count),  32'(b));
        check_eq({tag, "_color"}, 32'(bb.color),       32'(c));
    endtask

    initial begin
        int done_at, n_done, prof, placed, p, bias, k2, first_done, second_done, nd;
        logic [7:0] fav;
        bb.start = 1'b0;
        sb.start = 1'b0;
        for (int i = 0; i < NB; i++) mem[i] = 8'h00;
        for (int i = 0; i < NS; i++) smem[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bb.busy), 0);
        check_eq("rst_done", 32'(bb.done), 0);
        check_eq("rst_addr", 32'(bb.mem_addr), 0);
        check_big("rst", 0, 0, 0, 0);
        rst = 1'b0;

        // Frame of 8'hE0 with a stray start at cycle 5000
        for (int i = 0; i < NB; i++) mem[i] = 8'hE0;
        run_big(5000, done_at, n_done, prof);
        check_eq("e0_done_at", 32'(done_at), 32'(NB + 2));
        check_eq("e0_done_pulses", 32'(n_done), 1);
        check_eq("e0_profile", 32'(prof), 0);
        check_big("e0", NB, 0, 0, 1);

        // All-black frame
        for (int i = 0; i < NB; i++) mem[i] = 8'h00;
        run_big(0, done_at, n_done, prof);
        check_eq("zero_done_at", 32'(done_at), 32'(NB + 2));
        check_eq("zero_profile", 32'(prof), 0);
        check_big("zero", 0, 0, 0, 0);

        // Top half green, bottom half blue: tie goes to green
        for (int i = 0; i < NB; i++) mem[i] = (i / CAM_SCREEN_X < 60) ? 8'h1C : 8'h03;
        run_big(0, done_at, n_done, prof);
        check_eq("tie_done_at", 32'(done_at), 32'(NB + 2));
        check_eq("tie_profile", 32'(prof), 0);
        check_big("tie", 0, NB / 2, NB / 2, 2);

        // 100 red pixels at random positions, rest black
        for (int i = 0; i < NB; i++) mem[i] = 8'h00;
        placed = 0;
        while (placed < 100) begin
            p = int'($urandom_range(0, NB - 1));
            if (mem[p] == 8'h00) begin
                mem[p] = 8'hE0;
                placed++;
            end
        end

        // Abort that frame with reset at cycle 10000
        @(negedge clk);
        bb.start = 1'b1;
        @(posedge clk);
        #1;
        bb.start = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_busy", 32'(bb.busy), 0);
        check_eq("abort_done", 32'(bb.done), 0);
        check_eq("abort_addr", 32'(bb.mem_addr), 0);
        check_big("abort", 0, 0, 0, 0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bb.done || bb.busy) nd++;
        end
        check_eq("abort_quiet", 32'(nd), 0);

        // Fresh start on the same frame completes normally
        run_big(0, done_at, n_done, prof);
        check_eq("red100_done_at", 32'(done_at), 32'(NB + 2));
        check_eq("red100_done_pulses", 32'(n_done), 1);
        check_eq("red100_profile", 32'(prof), 0);
        check_big("red100", 100, 0, 0, 0);

        // Randomized small frames, some biased toward one color
        for (int f = 0; f < 12; f++) begin
            bias = int'($urandom_range(0, 60));
            case ($urandom_range(0, 2))
                0:       fav = 8'hE0 | 8'($urandom_range(0, 3));
                1:       fav = 8'h1C | 8'($urandom_range(0, 1));
                default: fav = 8'h03 | (8'($urandom_range(0, 1)) << 2);
            endcase
            for (int i = 0; i < NS; i++)
                smem[i] = (int'($urandom_range(0, 99)) < bias) ? fav : 8'($urandom);
            run_small($sformatf("rnd%0d", f));
        end

        // Start held high through DONE starts the next frame at once
        for (int i = 0; i < NS; i++) smem[i] = 8'($urandom);
        first_done  = -1;
        second_done = -1;
        nd = 0;
        @(negedge clk);
        sb.start = 1'b1;
        @(posedge clk);
        #1;
        for (k2 = 1; k2 <= 2 * NS + 10; k2++) begin
            @(posedge clk);
            #1;
            if (k2 == NS + 3) sb.start = 1'b0;
            if (sb.done) begin
                nd++;
                if (first_done < 0) first_done = k2;
                else if (second_done < 0) second_done = k2;
            end
        end
        sb.start = 1'b0;
        check_eq("hold_first_done", 32'(first_done), 32'(NS + 2));
        check_eq("hold_second_done", 32'(second_done), 32'(2 * NS + 5));
        check_eq("hold_done_pulses", 32'(nd), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
